// File: rtl/cnn_buf_pkg.sv
// cnn_buf_pkg
// Shared definitions for the CNN input buffer fetch path: the fetch FSM
// state encoding and the width of a feature-map memory word address.
// No ports (package).
package cnn_buf_pkg;

  // Memory word address width for feature-map storage.
  localparam int ADDR_W = 14;

  // Fetch controller states.
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    FETCH  = 2'b01,
    DRAIN  = 2'b10,
    FINISH = 2'b11
  } fetch_state_e;

endpackage

// File: rtl/fetch_skid.sv
// fetch_skid
// One-entry holding register for a memory return that could not be pushed
// into the FIFO in the cycle it arrived.
// Ports:
//   w_clk  - clock, rising edge
//   reset  - synchronous active-low reset, empties the entry
//   load   - capture din, entry becomes valid
//   unload - entry consumed, becomes empty (load wins if both are high)
//   din    - data to capture
//   data   - held element
//   valid  - entry occupied
module fetch_skid #(
  parameter int width = 16
) (
  input  logic             w_clk,
  input  logic             reset,
  input  logic             load,
  input  logic             unload,
  input  logic [width-1:0] din,
  output logic [width-1:0] data,
  output logic             valid
);

  // Holding register and its occupancy flag.
  always_ff @(posedge w_clk) begin
    if (!reset) begin
      valid <= 1'b0;
      data  <= {width{1'b0}};
    end else if (load) begin
      valid <= 1'b1;
      data  <= din;
    end else if (unload) begin
      valid <= 1'b0;
    end else begin
      valid <= valid;
    end
  end

endmodule

// File: rtl/input_fetch.sv
// input_fetch
// Streams input_featuremapsize consecutive memory words, starting at
// initial_address, into a downstream FIFO while honouring its full flag.
// Memory data arrives one cycle after the read strobe; a return that cannot
// be pushed (FIFO full or enable low) is parked in a one-entry skid register,
// and no new read is issued while that entry is occupied, so nothing is lost.
// read_enable, write_enable and fifo_wdata are decoded from registered state
// and the current is_full/enable so a push never coincides with a full FIFO.
// Optional feature: define INPUT_FETCH_STALL_CNT_EN to add stall_count, a
// saturating count of FETCH/DRAIN cycles that saw is_full=1.
// Ports:
//   w_clk, reset          - clock and synchronous active-low reset
//   enable                - run qualifier, low freezes progress
//   initial_address       - first memory word to read
//   input_featuremapsize  - number of elements to fetch
//   is_full               - downstream FIFO full
//   mem_rdata             - memory read data (one cycle after read_enable)
//   c_address/read_enable - memory read port
//   fifo_wdata/write_enable - FIFO push port
//   done                  - all elements pushed, held until enable drops
//   stall_count           - (INPUT_FETCH_STALL_CNT_EN only) stall cycles
module input_fetch
  import cnn_buf_pkg::*;
#(
  parameter int dimdata_size = 16,
  parameter int data_size    = 16
) (
  input  logic                    w_clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [ADDR_W-1:0]       initial_address,
  input  logic [dimdata_size-1:0] input_featuremapsize,
  input  logic                    is_full,
  input  logic [data_size-1:0]    mem_rdata,
  output logic [ADDR_W-1:0]       c_address,
  output logic                    read_enable,
  output logic [data_size-1:0]    fifo_wdata,
  output logic                    write_enable,
  output logic                    done
`ifdef INPUT_FETCH_STALL_CNT_EN
  ,
  output logic [15:0]             stall_count
`endif
);

  fetch_state_e            state_r;
  logic [dimdata_size-1:0] issued_r;
  logic [dimdata_size-1:0] pushed_r;
  logic                    ret_valid_r;

  logic                    skid_valid_s;
  logic [data_size-1:0]    skid_data_s;
  logic                    active_s;
  logic                    read_s;
  logic                    unload_s;
  logic                    direct_s;
  logic                    load_s;
  logic                    push_s;
  logic [data_size-1:0]    wdata_s;

  // Read/push decode; the skid entry always drains before fresh return data.
  always_comb begin
    active_s = (state_r == FETCH) || (state_r == DRAIN);
    read_s   = (state_r == FETCH) && enable && !is_full && !skid_valid_s &&
               (issued_r != input_featuremapsize);
    unload_s = active_s && enable && !is_full && skid_valid_s;
    direct_s = active_s && enable && !is_full && !skid_valid_s && ret_valid_r;
    // A return that cannot go straight out is parked in the skid entry.
    load_s   = ret_valid_r && !direct_s;
    push_s   = unload_s || direct_s;
    if (unload_s) begin
      wdata_s = skid_data_s;
    end else if (direct_s) begin
      wdata_s = mem_rdata;
    end else begin
      wdata_s = {data_size{1'b0}};
    end
  end

  assign read_enable  = read_s;
  assign write_enable = push_s;
  assign fifo_wdata   = wdata_s;

  fetch_skid #(
    .width (data_size)
  ) u_skid (
    .w_clk  (w_clk),
    .reset  (reset),
    .load   (load_s),
    .unload (unload_s),
    .din    (mem_rdata),
    .data   (skid_data_s),
    .valid  (skid_valid_s)
  );

  // Fetch FSM with address, issue/push counters and done flag.
  always_ff @(posedge w_clk) begin
    if (!reset) begin
      state_r     <= IDLE;
      c_address   <= {ADDR_W{1'b0}};
      issued_r    <= {dimdata_size{1'b0}};
      pushed_r    <= {dimdata_size{1'b0}};
      ret_valid_r <= 1'b0;
      done        <= 1'b0;
    end else begin
      // Memory data is valid exactly one cycle after a read strobe.
      ret_valid_r <= read_s;
      case (state_r)
        IDLE: begin
          if (enable) begin
            state_r   <= FETCH;
            c_address <= initial_address;
            issued_r  <= {dimdata_size{1'b0}};
            pushed_r  <= {dimdata_size{1'b0}};
            done      <= 1'b0;
          end
        end
        FETCH: begin
          if (read_s) begin
            c_address <= c_address + ADDR_W'(1);
            issued_r  <= issued_r + dimdata_size'(1);
          end
          if (push_s) begin
            pushed_r <= pushed_r + dimdata_size'(1);
          end
          if (issued_r == input_featuremapsize) begin
            if (pushed_r == input_featuremapsize) begin
              state_r <= FINISH;
              done    <= 1'b1;
            end else begin
              state_r <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (push_s) begin
            pushed_r <= pushed_r + dimdata_size'(1);
          end
          if (pushed_r == input_featuremapsize) begin
            state_r <= FINISH;
            done    <= 1'b1;
          end
        end
        FINISH: begin
          if (!enable) begin
            state_r <= IDLE;
            done    <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          done    <= 1'b0;
        end
      endcase
    end
  end

`ifdef INPUT_FETCH_STALL_CNT_EN
  logic [15:0] stall_cnt_r;

  // Saturating count of active cycles blocked by a full FIFO.
  always_ff @(posedge w_clk) begin
    if (!reset) begin
      stall_cnt_r <= 16'h0000;
    end else if ((state_r == IDLE) && enable) begin
      stall_cnt_r <= 16'h0000;
    end else if (active_s && is_full && (stall_cnt_r != 16'hFFFF)) begin
      stall_cnt_r <= stall_cnt_r + 16'h0001;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign stall_count = stall_cnt_r;
`endif

endmodule

// File: tb/tb_input_fetch.sv
// tb_input_fetch
// Directed bench for input_fetch. A behavioural memory returns pat(address)
// one cycle after each read; expected addresses and data are queued when a
// run is started and popped as the DUT reads and pushes.
module tb_input_fetch;

  logic        w_clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [13:0] initial_address;
  logic [15:0] input_featuremapsize;
  logic        is_full;
  logic [15:0] mem_rdata = 16'h0000;
  logic [13:0] c_address;
  logic        read_enable;
  logic [15:0] fifo_wdata;
  logic        write_enable;
  logic        done;
`ifdef INPUT_FETCH_STALL_CNT_EN
  logic [15:0] stall_count;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  int first_rd = -1;
  int first_wr = -1;

  logic [13:0] exp_addr_q[$];
  logic [15:0] exp_data_q[$];

  logic [13:0] snap_addr;
  logic        snap_re;
  logic        snap_we;
  logic [15:0] snap_wd;
  logic        snap_done;

  always #5 w_clk = ~w_clk;

  input_fetch #(
    .dimdata_size (16),
    .data_size    (16)
  ) dut (
    .w_clk                (w_clk),
    .reset                (reset),
    .enable               (enable),
    .initial_address      (initial_address),
    .input_featuremapsize (input_featuremapsize),
    .is_full              (is_full),
    .mem_rdata            (mem_rdata),
    .c_address            (c_address),
    .read_enable          (read_enable),
    .fifo_wdata           (fifo_wdata),
    .write_enable         (write_enable),
    .done                 (done)
`ifdef INPUT_FETCH_STALL_CNT_EN
    ,
    .stall_count          (stall_count)
`endif
  );

  function automatic logic [15:0] pat(input logic [13:0] a);
    return {2'b01, a} ^ 16'hC3A5;
  endfunction

  // Memory model: data for the strobed address appears one cycle later.
  always @(posedge w_clk) begin
    if (read_enable === 1'b1) mem_rdata <= pat(c_address);
    else mem_rdata <= 16'hDEAD;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Observe one cycle at the falling edge, score it, then move past the next rising edge.
  task automatic step();
    logic [13:0] ea;
    logic [15:0] ed;
    @(negedge w_clk);
    snap_addr = c_address;
    snap_re   = read_enable;
    snap_we   = write_enable;
    snap_wd   = fifo_wdata;
    snap_done = done;
    if (read_enable === 1'b1) begin
      check("rd_qualified", {30'd0, enable, is_full}, 32'd2);
      checks++;
      assert (exp_addr_q.size() != 0) else begin
        errors++;
        $error("FAIL rd_unexpected observed=%0h expected=none", c_address);
      end
      if (exp_addr_q.size() != 0) begin
        ea = exp_addr_q.pop_front();
        check("rd_addr", {18'd0, c_address}, {18'd0, ea});
      end
      rd_cnt++;
      if (rd_cnt == 1) first_rd = cyc;
    end
    if (write_enable === 1'b1) begin
      check("wr_not_full", {31'd0, is_full}, 32'd0);
      checks++;
      assert (exp_data_q.size() != 0) else begin
        errors++;
        $error("FAIL wr_unexpected observed=%0h expected=none", fifo_wdata);
      end
      if (exp_data_q.size() != 0) begin
        ed = exp_data_q.pop_front();
        check("wr_data", {16'd0, fifo_wdata}, {16'd0, ed});
      end
      wr_cnt++;
      if (wr_cnt == 1) first_wr = cyc;
    end
    @(posedge w_clk);
    #1;
    cyc++;
  endtask

  task automatic start(input logic [13:0] a, input logic [15:0] n);
    logic [13:0] t;
    for (int i = 0; i < int'(n); i++) begin
      t = a + 14'(i);
      exp_addr_q.push_back(t);
      exp_data_q.push_back(pat(t));
    end
    rd_cnt = 0;
    wr_cnt = 0;
    first_rd = -1;
    first_wr = -1;
    initial_address = a;
    input_featuremapsize = n;
    enable = 1'b1;
  endtask

  task automatic wait_done(input int budget);
    for (int k = 0; k < budget && snap_done !== 1'b1; k++) step();
    check("done_seen", {31'd0, snap_done}, 32'd1);
  endtask

  task automatic wait_reads(input int n, input int budget);
    for (int k = 0; k < budget && rd_cnt < n; k++) step();
    check("reads_seen", rd_cnt, n);
  endtask

  task automatic finish_run(input int n);
    check("rd_count", rd_cnt, n);
    check("wr_count", wr_cnt, n);
    check("queues_empty", exp_addr_q.size() + exp_data_q.size(), 0);
    enable = 1'b0;
    step();
    step();
    check("done_cleared", {31'd0, snap_done}, 32'd0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_addr"}, {18'd0, snap_addr}, 32'd0);
    check({tag, "_re"}, {31'd0, snap_re}, 32'd0);
    check({tag, "_we"}, {31'd0, snap_we}, 32'd0);
    check({tag, "_wdata"}, {16'd0, snap_wd}, 32'd0);
    check({tag, "_done"}, {31'd0, snap_done}, 32'd0);
  endtask

  initial begin
    reset = 1'b0;
    enable = 1'b0;
    is_full = 1'b0;
    initial_address = 14'd0;
    input_featuremapsize = 16'd0;
    snap_done = 1'b0;
    step();
    step();
    check_zero("reset");
    reset = 1'b1;

    // Basic run: four reads at 100..103, pushes one cycle behind.
    start(14'd100, 16'd4);
    wait_done(40);
    check("push_latency", first_wr - first_rd, 1);
    finish_run(4);

    // FIFO full on the first return: element parked in skid, then pushed.
    start(14'd300, 16'd3);
    wait_reads(1, 20);
    is_full = 1'b1;
    step();
    check("full_no_push", {31'd0, snap_we}, 32'd0);
    is_full = 1'b0;
    step();
    check("skid_push", {31'd0, snap_we}, 32'd1);
    wait_done(40);
    finish_run(3);

    // Address wrap 16382, 16383, 0, 1.
    start(14'd16382, 16'd4);
    wait_done(40);
    finish_run(4);

    // Empty feature map.
    start(14'd500, 16'd0);
    wait_done(10);
    finish_run(0);

    // Reset after the second read, then restart from initial_address.
    start(14'd1000, 16'd8);
    wait_reads(2, 20);
    reset = 1'b0;
    step();
    reset = 1'b1;
    enable = 1'b0;
    step();
    check_zero("midreset");
    exp_addr_q.delete();
    exp_data_q.delete();
    start(14'd1000, 16'd8);
    wait_done(60);
    finish_run(8);

    // Enable dropped mid-run: no activity, in-flight return survives.
    start(14'd2000, 16'd6);
    wait_reads(3, 20);
    enable = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("hold_re", {31'd0, snap_re}, 32'd0);
      check("hold_we", {31'd0, snap_we}, 32'd0);
    end
    enable = 1'b1;
    wait_done(60);
    finish_run(6);

    // Five full cycles right after entering FETCH.
    start(14'd40, 16'd3);
    step();
    is_full = 1'b1;
    for (int k = 0; k < 5; k++) step();
    is_full = 1'b0;
    wait_done(40);
`ifdef INPUT_FETCH_STALL_CNT_EN
    check("stall_count", {16'd0, stall_count}, 32'd5);
`endif
    finish_run(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
